// File: rtl/shift_arbiter_seq.sv
// shift_arbiter_seq
//   Two-requester round-robin front end feeding a bit-serial shifter. One
//   operation is held at a time: it is accepted in IDLE, shifted one bit per
//   cycle in SHIFT, and presented in DONE until the consumer takes it.
//
// Handshake: a transfer happens on any rising edge where valid && ready are
//   both high. reqX_ready is combinational, is high only in IDLE for the
//   granted requester, and is never high while rstb is low. res_valid stays
//   high, with res_z/res_id held stable, until res_ready is seen.
//
// Ports
//   clk, rstb                      clock, synchronous active-low reset
//   reqX_valid/ready               request handshake, X = 0, 1
//   reqX_a, reqX_shamt, reqX_op    operand, shift amount, op
//                                  (00 SLL, 01 SRL, 10 SRA, 11 pass)
//   res_valid/ready, res_z, res_id result handshake, data, owning requester
//   busy                           high whenever the FSM is not IDLE
//   dbg_state                      FSM state (0 IDLE, 1 SHIFT, 2 DONE)
module shift_arbiter_seq #(
    parameter int N   = 32,
    parameter int SHW = 5
) (
    input  logic           clk,
    input  logic           rstb,
    input  logic           req0_valid,
    output logic           req0_ready,
    input  logic [N-1:0]   req0_a,
    input  logic [SHW-1:0] req0_shamt,
    input  logic [1:0]     req0_op,
    input  logic           req1_valid,
    output logic           req1_ready,
    input  logic [N-1:0]   req1_a,
    input  logic [SHW-1:0] req1_shamt,
    input  logic [1:0]     req1_op,
    output logic           res_valid,
    input  logic           res_ready,
    output logic [N-1:0]   res_z,
    output logic           res_id,
    output logic           busy,
    output logic [1:0]     dbg_state
);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    localparam logic [1:0] OP_SLL  = 2'b00;
    localparam logic [1:0] OP_SRL  = 2'b01;
    localparam logic [1:0] OP_SRA  = 2'b10;
    localparam logic [1:0] OP_PASS = 2'b11;

    state_t         state_q, state_d;
    logic [N-1:0]   acc_q, acc_d;
    logic [SHW-1:0] cnt_q, cnt_d;
    logic [1:0]     op_q, op_d;
    logic           id_q, id_d;
    logic           last_grant_q, last_grant_d;

    logic           gnt0, gnt1;
    logic           sel;
    logic [N-1:0]   sel_a;
    logic [SHW-1:0] sel_shamt;
    logic [1:0]     sel_op;

    // Round robin: a lone valid wins; on a tie the requester not granted
    // last time wins (last_grant resets to 1 so req0 takes the first tie).
    always_comb begin
        gnt0 = req0_valid && (!req1_valid || last_grant_q);
        gnt1 = req1_valid && (!req0_valid || !last_grant_q);
        req0_ready = rstb && (state_q == S_IDLE) && gnt0;
        req1_ready = rstb && (state_q == S_IDLE) && gnt1;
    end

    always_comb begin
        sel       = req1_ready;
        sel_a     = sel ? req1_a     : req0_a;
        sel_shamt = sel ? req1_shamt : req0_shamt;
        sel_op    = sel ? req1_op    : req0_op;
    end

    always_comb begin
        state_d      = state_q;
        acc_d        = acc_q;
        cnt_d        = cnt_q;
        op_d         = op_q;
        id_d         = id_q;
        last_grant_d = last_grant_q;
        case (state_q)
            S_IDLE: begin
                if (req0_ready || req1_ready) begin
                    acc_d        = sel_a;
                    cnt_d        = sel_shamt;
                    op_d         = sel_op;
                    id_d         = sel;
                    last_grant_d = sel;
                    // Zero shift or pass-through has nothing to iterate.
                    if ((sel_shamt != '0) && (sel_op != OP_PASS))
                        state_d = S_SHIFT;
                    else
                        state_d = S_DONE;
                end
            end
            S_SHIFT: begin
                case (op_q)
                    OP_SLL:  acc_d = {acc_q[N-2:0], 1'b0};
                    OP_SRL:  acc_d = {1'b0, acc_q[N-1:1]};
                    OP_SRA:  acc_d = {acc_q[N-1], acc_q[N-1:1]};
                    default: acc_d = acc_q;
                endcase
                cnt_d = cnt_q - 1'b1;
                if (cnt_q == SHW'(1))
                    state_d = S_DONE;
            end
            S_DONE: begin
                if (res_ready)
                    state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rstb) begin
            state_q      <= S_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            op_q         <= OP_SLL;
            id_q         <= 1'b0;
            last_grant_q <= 1'b1;
        end else begin
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            op_q         <= op_d;
            id_q         <= id_d;
            last_grant_q <= last_grant_d;
        end
    end

    // All result-side outputs come straight from flops.
    assign res_valid = (state_q == S_DONE);
    assign res_z     = acc_q;
    assign res_id    = id_q;
    assign busy      = (state_q != S_IDLE);
    assign dbg_state = state_q;

endmodule

// File: doc/shift_arbiter_seq.md
SHIFT_ARBITER_SEQ -- requirements
Module: shift_arbiter_seq

Interface
REQ-001 The block SHALL have parameter N, default 32, giving the operand/result width in bits.
REQ-002 The block SHALL have parameter SHW, default 5, giving the shift-amount width (log2 N).
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-004 The block SHALL have port rstb, input, 1 bit: reset, synchronous and active-low.
REQ-005 The block SHALL have ports req0_valid / req1_valid, input, 1 bit each: requester has an operation pending.
REQ-006 The block SHALL have ports req0_ready / req1_ready, output, 1 bit each: request accepted this cycle.
REQ-007 The block SHALL have ports req0_a / req1_a, input, N bits each: operand to shift.
REQ-008 The block SHALL have ports req0_shamt / req1_shamt, input, SHW bits each: shift amount, 0..N-1.
REQ-009 The block SHALL have ports req0_op / req1_op, input, 2 bits each: 00 SLL, 01 SRL, 10 SRA, 11 pass-through.
REQ-010 The block SHALL have port res_valid, output, 1 bit: result available.
REQ-011 The block SHALL have port res_ready, input, 1 bit: consumer takes result.
REQ-012 The block SHALL have port res_z, output, N bits: shifted result.
REQ-013 The block SHALL have port res_id, output, 1 bit: index of the requester owning res_z.
REQ-014 The block SHALL have port busy, output, 1 bit: high whenever state is not IDLE.

Function
REQ-015 The block SHALL implement states IDLE, SHIFT, DONE; it SHALL hold one operation at a time, with no overlap or back-to-back acceptance.
REQ-016 In IDLE with at least one valid, the block SHALL grant exactly one requester: the sole valid one, or, if both are valid, the one not granted last (round-robin pointer last_grant).
REQ-017 reqX_ready SHALL be combinational, high only in IDLE for the granted requester; a transfer occurs when reqX_valid && reqX_ready.
REQ-018 On transfer the block SHALL latch a into accumulator acc, shamt into counter cnt, op, and id; update last_grant to id; and move to SHIFT if cnt != 0 and op != 11, else to DONE.
REQ-019 In SHIFT, each cycle acc SHALL shift by exactly 1 bit: SLL shifts left with 0 fill; SRL shifts right with 0 fill; SRA shifts right filling acc[N-1]. cnt SHALL decrement; when cnt == 1, the next state SHALL be DONE.
REQ-020 Latency: for a transfer at cycle T with amount k, res_valid SHALL first be high at cycle T+1+k (k = 0 or op 11 gives T+1).
REQ-021 In DONE, res_valid SHALL be 1; res_z = acc and res_id SHALL stay stable until res_valid && res_ready, then the block SHALL return to IDLE (ready not asserted in that same cycle).
REQ-022 res_valid SHALL be 0 in IDLE and SHIFT.
REQ-023 Requesters SHALL hold valid/a/shamt/op stable until ready; the block SHALL tolerate a valid dropped before grant, taking no action.
REQ-024 Shift amount SHALL be taken as the unsigned SHW-bit value; no amount outside 0..N-1 is representable.

Reset
REQ-025 While rstb is low at a clock edge: state -> IDLE, res_valid -> 0, res_z -> 0, res_id -> 0, busy -> 0, cnt -> 0, acc -> 0, last_grant -> 1 (req0 wins the first tie); req0_ready/req1_ready SHALL be 0 while rstb is low.
REQ-026 Reset asserted mid-SHIFT or mid-DONE SHALL abandon the operation with no result produced.

Verification
REQ-027 req0 SRL, a=0x80000000, shamt=4, accepted at T -> res_z=0x08000000, res_id=0, res_valid first high at T+5.
REQ-028 req1 SRA, a=0x80000000, shamt=31 -> res_z=0xFFFFFFFF at T+32; SLL a=0x00000001, shamt=31 -> 0x80000000.
REQ-029 Both valid continuously after reset, res_ready=1 -> grant order 0,1,0,1; res_id alternates; never two readies in one cycle.
REQ-030 SLL shamt=0, a=0x00001234, and op=11, a=0xDEADBEEF, shamt=7 -> each gives res_valid at T+1 with res_z equal to a.
REQ-031 res_ready held low 10 cycles in DONE -> res_z/res_id stable, busy=1, both readies 0; on release, returns to IDLE next cycle.
REQ-032 rstb low for one cycle during SHIFT (cnt=3) -> next cycle busy=0, res_valid=0, res_z=0; a pending req0 is granted the following cycle.
